// File: rtl/button_event_scheduler.sv
// Latches active-low press pulses, arbitrates among pending buttons and offers one event at a
// time on a valid/ready port. Define BTN_SCHED_RR_EN for round-robin; default is fixed priority.
module button_event_scheduler #(
  parameter int N_BTN        = 5,
  parameter int COOLDOWN_CYC = 16,
  parameter int TIMEOUT_CYC  = 0,
  parameter int IDW          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [N_BTN-1:0] drop,
  output logic             timeout,
  output logic             busy
);

  localparam int CMAX = (COOLDOWN_CYC > TIMEOUT_CYC) ? COOLDOWN_CYC : TIMEOUT_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] CD_LAST = CW'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, OFFER, COOL} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N_BTN-1:0] pending, pending_n, clr, press;
  logic [IDW-1:0]   rr_ptr, rr_ptr_n, win_id, evt_id_n;
  logic             win_found, evt_valid_n, timeout_n, fire;

`ifdef BTN_SCHED_RR_EN
  int idx;
  // Search begins just after the last served button and wraps.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr_ptr;

  always_comb begin
    win_found = |pending;
    win_id    = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pending[i]) win_id = IDW'(i);
  end
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    evt_valid_n = evt_valid;
    evt_id_n    = evt_id;
    rr_ptr_n    = rr_ptr;
    timeout_n   = 1'b0;
    fire        = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n     = OFFER;
          evt_valid_n = 1'b1;
          evt_id_n    = win_id;
          cnt_n       = '0;
        end
      end
      OFFER: begin
        // Accept takes precedence over an expiring offer on the same edge.
        if (evt_ready || (TIMEOUT_CYC != 0 && cnt == TO_LAST)) begin
          fire        = 1'b1;
          timeout_n   = !evt_ready;
          evt_valid_n = 1'b0;
          rr_ptr_n    = evt_id;
          cnt_n       = '0;
          state_n     = (COOLDOWN_CYC == 0) ? IDLE : COOL;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      COOL: begin
        if (cnt == CD_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A press arriving on the same edge its button is cleared survives as a new request.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_BTN; i++)
      clr[i] = fire && (evt_id == IDW'(i));
  end

  assign press     = ~btn_n;
  assign pending_n = press | (pending & ~clr);
  assign busy      = (state != IDLE) || (|pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      rr_ptr    <= IDW'(N_BTN - 1);
      evt_valid <= 1'b0;
      evt_id    <= '0;
      drop      <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      rr_ptr    <= rr_ptr_n;
      evt_valid <= evt_valid_n;
      evt_id    <= evt_id_n;
      drop      <= press & pending & ~clr;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an event-level reference model.
module tb_button_event_scheduler;
  localparam int N  = 5;
  localparam int CD = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_n;
  logic         evt_ready;
  logic         evt_valid;
  logic [2:0]   evt_id;
  logic [N-1:0] drop;
  logic         timeout;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int grants[$];

  // reference model state
  bit [N-1:0] m_pend;
  bit         m_off;
  int         m_id, m_age, m_cool, m_rr;
  bit [N-1:0] m_drop;
  bit         m_to;

  button_event_scheduler #(.N_BTN(N), .COOLDOWN_CYC(CD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .drop(drop), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef BTN_SCHED_RR_EN
    for (int k = 1; k <= N; k++)
      if (m_pend[(m_rr + k) % N]) return (m_rr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (m_pend[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_step(input logic [N-1:0] b, input logic r, input logic rs);
    bit [N-1:0] clr;
    bit [N-1:0] pr;
    if (rs) begin
      m_pend = '0; m_off = 0; m_id = 0; m_age = 0; m_cool = 0; m_rr = N - 1;
      m_drop = '0; m_to = 0;
      return;
    end
    clr = '0;
    pr  = ~b;
    m_to = 0;
    if (m_off) begin
      if (r || (TO != 0 && m_age == TO - 1)) begin
        clr[m_id] = 1'b1;
        m_rr   = m_id;
        m_off  = 0;
        m_cool = CD;
        m_to   = !r;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_pend != 0) begin
      m_id  = pick();
      m_off = 1;
      m_age = 0;
    end
    m_drop = pr & m_pend & ~clr;
    m_pend = pr | (m_pend & ~clr);
  endtask

  task automatic compare();
    chk("evt_valid", int'(evt_valid), int'(m_off));
    if (m_off) chk("evt_id", int'(evt_id), m_id);
    chk("drop", int'(drop), int'(m_drop));
    chk("timeout", int'(timeout), int'(m_to));
    chk("busy", int'(busy), int'(m_off || m_cool > 0 || m_pend != 0));
  endtask

  // One clock: drive, record any handshake, advance model at the edge, compare mid-cycle.
  task automatic cyc(input logic [N-1:0] b, input logic r, input logic rs);
    btn_n = b; evt_ready = r; rst = rs;
    if (!rs && evt_valid === 1'b1 && r) grants.push_back(int'(evt_id));
    @(posedge clk);
    model_step(b, r, rs);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle(input int lim, input logic r);
    int n = 0;
    while ((busy !== 1'b0 || evt_valid !== 1'b0) && n < lim) begin
      cyc(5'h1f, r, 1'b0);
      n++;
    end
    chk("idle_bound", int'(busy === 1'b0), 1);
  endtask

  task automatic wait_valid(input int lim, input logic r);
    int n = 0;
    while (evt_valid !== 1'b1 && n < lim) begin
      cyc(5'h1f, r, 1'b0);
      n++;
    end
    chk("valid_bound", int'(evt_valid === 1'b1), 1);
  endtask

  initial begin
    int vc;
    int thr;
    logic [N-1:0] b;
    // reset with every button held pressed
    repeat (3) cyc(5'h00, 1'b0, 1'b1);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_timeout", int'(timeout), 0);
    repeat (4) cyc(5'h1f, 1'b0, 1'b0);
    chk("no_evt_after_rst", int'(evt_valid), 0);

    // single press, latency and cooldown
    cyc(5'b11011, 1'b1, 1'b0);
    chk("lat_c1", int'(evt_valid), 0);
    cyc(5'h1f, 1'b1, 1'b0);
    chk("lat_c2_valid", int'(evt_valid), 1);
    chk("lat_c2_id", int'(evt_id), 2);
    cyc(5'h1f, 1'b1, 1'b0);
    chk("one_cycle", int'(evt_valid), 0);
    repeat (15) cyc(5'h1f, 1'b1, 1'b0);
    chk("cool_busy", int'(busy), 1);
    cyc(5'h1f, 1'b1, 1'b0);
    chk("cool_done", int'(busy), 0);

    // simultaneous presses 0,3,4, twice
    for (int rnd = 0; rnd < 2; rnd++) begin
      grants.delete();
      cyc(5'b00110, 1'b1, 1'b0);
      wait_idle(150, 1'b1);
      chk("arb_n", grants.size(), 3);
      if (grants.size() == 3) begin
        chk("arb_0", grants[0], 0);
        chk("arb_1", grants[1], 3);
        chk("arb_2", grants[2], 4);
      end
    end

    // 1 held pending while 0 is re-pressed on every grant
    grants.delete();
    cyc(5'b11100, 1'b1, 1'b0);
    vc = 0;
    while (grants.size() < 4 && vc < 200) begin
      cyc((evt_valid === 1'b1) ? 5'b11110 : 5'h1f, 1'b1, 1'b0);
      vc++;
    end
    chk("fair_n", int'(grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
`ifdef BTN_SCHED_RR_EN
      chk("fair_0", grants[0], 0); chk("fair_1", grants[1], 1);
      chk("fair_2", grants[2], 0); chk("fair_3", grants[3], 1);
`else
      chk("fair_0", grants[0], 0); chk("fair_1", grants[1], 0);
      chk("fair_2", grants[2], 0); chk("fair_3", grants[3], 0);
`endif
    end
    wait_idle(150, 1'b1);

    // re-press while pending -> drop; re-press on accept edge -> kept
    grants.delete();
    cyc(5'b11101, 1'b0, 1'b0);
    cyc(5'h1f, 1'b0, 1'b0);
    cyc(5'b11101, 1'b0, 1'b0);
    chk("drop_pulse", int'(drop), 2);
    cyc(5'h1f, 1'b0, 1'b0);
    chk("drop_once", int'(drop), 0);
    cyc(5'h1f, 1'b1, 1'b0);
    wait_idle(60, 1'b1);
    chk("single_evt", grants.size(), 1);
    grants.delete();
    cyc(5'b11101, 1'b0, 1'b0);
    cyc(5'h1f, 1'b0, 1'b0);
    cyc(5'b11101, 1'b1, 1'b0);
    chk("no_drop_on_accept", int'(drop), 0);
    wait_valid(40, 1'b0);
    chk("second_id", int'(evt_id), 1);
    cyc(5'h1f, 1'b1, 1'b0);
    wait_idle(60, 1'b1);
    chk("two_evts", grants.size(), 2);

    // offer timeout
    grants.delete();
    cyc(5'b10111, 1'b0, 1'b0);
    cyc(5'h1f, 1'b0, 1'b0);
    vc = 0;
    while (evt_valid === 1'b1 && vc < 20) begin
      vc++;
      cyc(5'h1f, 1'b0, 1'b0);
    end
    chk("to_len", vc, 8);
    chk("to_pulse", int'(timeout), 1);
    cyc(5'h1f, 1'b0, 1'b0);
    chk("to_once", int'(timeout), 0);
    wait_idle(60, 1'b0);
    chk("to_no_grant", grants.size(), 0);
    // ready on the expiring edge: accept wins
    cyc(5'b10111, 1'b0, 1'b0);
    cyc(5'h1f, 1'b0, 1'b0);
    repeat (7) cyc(5'h1f, 1'b0, 1'b0);
    chk("to_edge_valid", int'(evt_valid), 1);
    cyc(5'h1f, 1'b1, 1'b0);
    chk("to_edge_no_pulse", int'(timeout), 0);
    chk("to_edge_grant", grants.size(), 1);
    wait_idle(60, 1'b0);

    // reset mid-offer with 0 and 2 pending
    cyc(5'b11010, 1'b0, 1'b0);
    cyc(5'h1f, 1'b0, 1'b0);
    chk("pre_rst_valid", int'(evt_valid), 1);
    cyc(5'h1f, 1'b0, 1'b1);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    vc = 0;
    repeat (30) begin
      cyc(5'h1f, 1'b1, 1'b0);
      if (evt_valid === 1'b1) vc++;
    end
    chk("mid_rst_quiet", vc, 0);

    // randomized traffic in phases of different consumer readiness
    for (int ph = 0; ph < 6; ph++) begin
      thr = (ph % 3 == 0) ? 50 : ((ph % 3 == 1) ? 4 : 90);
      for (int i = 0; i < 500; i++) begin
        for (int k = 0; k < N; k++) b[k] = ($urandom_range(5) != 0);
        cyc(b, ($urandom_range(99) < thr), ($urandom_range(299) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
